// File: rtl/beat_timing_gen_pkg.sv
// Shared types and encodings for the beat/phase timing generator.
// Beat and phase codes match the ones the hardwired controller decodes.
package beat_timing_gen_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      BEAT_W1 = 2'b01,
      BEAT_W2 = 2'b10,
      BEAT_W3 = 2'b11
   } beat_t;

   typedef enum logic [1:0] {
      PH_T1 = 2'b01,
      PH_T2 = 2'b10,
      PH_T3 = 2'b11
   } phase_t;

   // Map a 1..3 code onto a one-hot {3,2,1} vector; code 0 gives all zero.
   function automatic logic [2:0] onehot3(input logic [1:0] code);
      onehot3 = {code == 2'd3, code == 2'd2, code == 2'd1};
   endfunction

endpackage

// File: rtl/beat_timing_gen_qd_edge_sync.sv
// Start-button synchroniser with a one-cycle rising-edge pulse.
// The pulse is high for one clock after the synchronised level goes 0->1.
module qd_edge_sync #(
   parameter int SYNC_DEPTH = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic qd,
   output logic rise
);

   logic [SYNC_DEPTH-1:0] sync;
   logic                  prev;

   // Shift the raw button level through the chain; keep the last stage's history.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_DEPTH-2:0], qd};
         prev <= sync[SYNC_DEPTH-1];
      end
   end

   assign rise = sync[SYNC_DEPTH-1] & ~prev;

endmodule

// File: rtl/beat_timing_gen.sv
// Beat/phase sequencer driving w1..w3 and t1..t3 into the controller.
// Starts on a qd edge, steps beats on short/long/stop sampled in the last T3 cycle.
module beat_timing_gen
   import beat_timing_gen_pkg::*;
#(
   parameter int T_CYCLES   = 1,
   parameter int SYNC_DEPTH = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic qd,
   input  logic short,
   input  logic long,
   input  logic stop,
   output logic w1,
   output logic w2,
   output logic w3,
   output logic t1,
   output logic t2,
   output logic t3,
   output logic run
);

   localparam int CW = $clog2(T_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(T_CYCLES - 1);

   state_t         state, n_state;
   beat_t          beat, n_beat;
   phase_t         phase, n_phase;
   logic [CW-1:0]  cnt, n_cnt;
   logic           rise;
   logic           last;
   logic           n_run;

   qd_edge_sync #(
      .SYNC_DEPTH(SYNC_DEPTH)
   ) u_sync (
      .clk (clk),
      .clr (clr),
      .qd  (qd),
      .rise(rise)
   );

   assign last = (cnt == CNT_LAST);

   // Sequencer state registers.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= ST_IDLE;
         beat  <= BEAT_W1;
         phase <= PH_T1;
         cnt   <= '0;
      end else begin
         state <= n_state;
         beat  <= n_beat;
         phase <= n_phase;
         cnt   <= n_cnt;
      end
   end

   // Next state: start on qd edge, count cycles, step phase, pick next beat.
   always_comb begin
      n_state = state;
      n_beat  = beat;
      n_phase = phase;
      n_cnt   = cnt;
      unique case (1'b1)
         (state == ST_IDLE): begin
            if (rise) begin
               n_state = ST_RUN;
               n_beat  = BEAT_W1;
               n_phase = PH_T1;
               n_cnt   = '0;
            end
         end
         (state == ST_RUN && !last): begin
            n_cnt = cnt + CW'(1);
         end
         (state == ST_RUN && last): begin
            n_cnt = '0;
            unique case (phase)
               PH_T1: n_phase = PH_T2;
               PH_T2: n_phase = PH_T3;
               PH_T3: begin
                  n_phase = PH_T1;
                  if (stop) begin
                     n_state = ST_IDLE;
                  end else if (short) begin
                     n_beat = BEAT_W1;
                  end else if (beat == BEAT_W1) begin
                     n_beat = BEAT_W2;
                  end else if (beat == BEAT_W2) begin
                     n_beat = long ? BEAT_W3 : BEAT_W1;
                  end else begin
                     n_beat = BEAT_W1;
                  end
               end
               default: n_phase = PH_T1;
            endcase
         end
         default: n_state = ST_IDLE;
      endcase
   end

   assign n_run = (n_state == ST_RUN);

   // Registered beat/phase decode so outputs never see inputs combinationally.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         run          <= 1'b0;
         {w3, w2, w1} <= 3'b000;
         {t3, t2, t1} <= 3'b000;
      end else begin
         run          <= n_run;
         {w3, w2, w1} <= n_run ? onehot3(n_beat) : 3'b000;
         {t3, t2, t1} <= n_run ? onehot3(n_phase) : 3'b000;
      end
   end

endmodule

// File: tb/tb_beat_timing_gen.sv
// Bench for beat_timing_gen: T_CYCLES=1 and T_CYCLES=3 instances share stimulus.
// A cycle-count model is compared every cycle; directed literals pin key points.
module tb_beat_timing_gen;

   logic clk = 1'b0;
   logic clr;
   logic qd;
   logic short;
   logic long;
   logic stop;
   wire [6:0] v1;
   wire [6:0] v3;

   int errors = 0;
   int checks = 0;

   beat_timing_gen #(.T_CYCLES(1), .SYNC_DEPTH(2)) u1 (
      .clk(clk), .clr(clr), .qd(qd),
      .short(short), .long(long), .stop(stop),
      .w1(v1[5]), .w2(v1[4]), .w3(v1[3]),
      .t1(v1[2]), .t2(v1[1]), .t3(v1[0]),
      .run(v1[6])
   );

   beat_timing_gen #(.T_CYCLES(3), .SYNC_DEPTH(2)) u3 (
      .clk(clk), .clr(clr), .qd(qd),
      .short(short), .long(long), .stop(stop),
      .w1(v3[5]), .w2(v3[4]), .w3(v3[3]),
      .t1(v3[2]), .t2(v3[1]), .t3(v3[0]),
      .run(v3[6])
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [6:0] got,
                      input logic [6:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
      end
   endtask

   // Model: k counts cycles within a beat (0..3T-1); phase = k/T + 1.
   int   tv[2] = '{1, 3};
   int   m_run[2] = '{0, 0};
   int   m_beat[2] = '{1, 1};
   int   m_k[2] = '{0, 0};
   logic h1 = 1'b0;
   logic h2 = 1'b0;
   logic h3 = 1'b0;
   logic m_rise;

   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
         for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_beat[i] = 1; m_k[i] = 0;
         end
      end else begin
         m_rise = h2 && !h3;
         h3 = h2; h2 = h1; h1 = qd;
         for (int i = 0; i < 2; i++) begin
            if (m_run[i] == 0) begin
               if (m_rise) begin
                  m_run[i] = 1; m_beat[i] = 1; m_k[i] = 0;
               end
            end else if (m_k[i] == 3 * tv[i] - 1) begin
               m_k[i] = 0;
               if (stop) m_run[i] = 0;
               else if (short) m_beat[i] = 1;
               else if (m_beat[i] == 1) m_beat[i] = 2;
               else if (m_beat[i] == 2) m_beat[i] = long ? 3 : 1;
               else m_beat[i] = 1;
            end else begin
               m_k[i] = m_k[i] + 1;
            end
         end
      end
   end

   function automatic logic [6:0] expv(input int i);
      int ph;
      ph = m_k[i] / tv[i] + 1;
      if (m_run[i] == 0) return 7'b0;
      return {1'b1, m_beat[i] == 1, m_beat[i] == 2, m_beat[i] == 3,
              ph == 1, ph == 2, ph == 3};
   endfunction

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("model_T1", v1, expv(0));
      chk("model_T3", v3, expv(1));
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      clr = 1'b0; qd = 1'b0; short = 1'b0; long = 1'b0; stop = 1'b0;
      step(2);
      chk("reset_T1", v1, 7'b0);
      chk("reset_T3", v3, 7'b0);
      clr = 1'b1;
      step(2);

      // Plain sequence with T=1: W1, W2, W1 (W3 skipped).
      qd = 1'b1;
      step(3); chk("start_w1t1", v1, 7'b1100100);
      qd = 1'b0;
      step(1); chk("seq_w1t2", v1, 7'b1100010);
      step(1); chk("seq_w1t3", v1, 7'b1100001);
      step(1); chk("seq_w2t1", v1, 7'b1010100);
      step(1); chk("seq_w2t2", v1, 7'b1010010);
      step(1); chk("seq_w2t3", v1, 7'b1010001);
      step(1); chk("seq_w1t1", v1, 7'b1100100);

      // long held: W1 -> W2 -> W3 -> W1.
      long = 1'b1;
      step(6); chk("long_w3t1", v1, 7'b1001100);
      step(3); chk("w3_to_w1", v1, 7'b1100100);

      // short in W1, then short beating long in W2.
      short = 1'b1;
      step(3); chk("short_w1", v1, 7'b1100100);
      short = 1'b0;
      step(3); chk("w1_to_w2", v1, 7'b1010100);
      short = 1'b1;
      step(3); chk("short_beats_long", v1, 7'b1100100);
      short = 1'b0; long = 1'b0;

      // stop in W1/T3, held qd gives no restart, fresh press does.
      stop = 1'b1; qd = 1'b1;
      step(2); chk("stop_w1t3", v1, 7'b1100001);
      step(1); chk("stop_halt", v1, 7'b0);
      stop = 1'b0;
      step(5); chk("qd_held_idle", v1, 7'b0);
      qd = 1'b0;
      step(3);
      qd = 1'b1;
      step(2); chk("restart_wait", v1, 7'b0);
      step(1); chk("restart_w1t1", v1, 7'b1100100);
      qd = 1'b0;

      // Asynchronous clear mid-W2/T2.
      step(4); chk("mid_w2t2", v1, 7'b1010010);
      clr = 1'b0;
      #1;
      chk("async_clr_T1", v1, 7'b0);
      chk("async_clr_T3", v3, 7'b0);
      step(2);
      clr = 1'b1;
      step(6); chk("stay_idle", v1, 7'b0);

      // T=3 phase widths and a short pulse inside T2 only.
      qd = 1'b1;
      step(3); chk("t3_start", v3, 7'b1100100);
      qd = 1'b0;
      step(2); chk("t3_t1_hold", v3, 7'b1100100);
      step(1); chk("t3_t2", v3, 7'b1100010);
      short = 1'b1;
      step(1);
      short = 1'b0;
      step(5); chk("t2_short_ignored", v3, 7'b1010100);

      step(20);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
